// File: rtl/cgra0_conf_receiver.sv
// Per-PE config receiver: collects CONF_WORDS fragments, commits atomically, forwards every word (optional parity: CGRA_CONF_PARITY_EN).
// Latency: forward bus and commit both one cycle after the input word; no backpressure, accepts a word every cycle.
module cgra0_conf_receiver #(
  parameter logic [15:0] PE_ID      = 16'd0,
  parameter int          CONF_WORDS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [63:0]                conf_in_bus,
  output logic [63:0]                conf_fwd_bus,
  output logic [CONF_WORDS*44-1:0]   conf_out,
  output logic                       conf_valid,
  output logic                       conf_loaded,
  output logic                       conf_err
);

  localparam int                    CW        = CONF_WORDS * 44;
  localparam logic [CONF_WORDS-1:0] MASK_FULL = '1;
  localparam logic [4:0]            NUM_FRAGS = 5'(CONF_WORDS);

  typedef enum logic {IDLE, COLLECT} state_e;

  logic [15:0] dest_id;
  logic [3:0]  frag_idx;
  logic [43:0] payload;
  logic        word_vld, id_hit, idx_ok, parity_ok, match, complete;

  assign dest_id  = conf_in_bus[15:0];
  assign frag_idx = conf_in_bus[19:16];
  assign word_vld = |conf_in_bus;
  assign id_hit   = (dest_id == PE_ID) || (dest_id == 16'hFFFF);
  assign idx_ok   = {1'b0, frag_idx} < NUM_FRAGS;

`ifdef CGRA_CONF_PARITY_EN
  // Bit 63 carries even parity over the whole word, so the top payload bit is stored as 0.
  assign payload   = {1'b0, conf_in_bus[62:20]};
  assign parity_ok = ~(^conf_in_bus);
`else
  assign payload   = conf_in_bus[63:20];
  assign parity_ok = 1'b1;
`endif

  assign match = word_vld & id_hit & idx_ok & parity_ok;

  state_e                state_q, state_d;
  logic [CONF_WORDS-1:0] mask_q, mask_d, mask_new;
  logic [CW-1:0]         shadow_q, shadow_d, merged;
  logic [CW-1:0]         out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  loaded_q, loaded_d;
  logic [63:0]           fwd_q;

  // Shadow and mask as they would look with the current word folded in.
  always_comb begin
    merged   = shadow_q;
    mask_new = mask_q;
    for (int k = 0; k < CONF_WORDS; k++) begin
      if (frag_idx == 4'(k)) begin
        merged[k*44 +: 44] = payload;
        mask_new[k]        = 1'b1;
      end
    end
  end

  assign complete = match && (mask_new == MASK_FULL);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    loaded_d = loaded_q;
    if (match) begin
      shadow_d = merged;
      mask_d   = mask_new;
    end
    if (complete) begin
      out_d    = merged;
      valid_d  = 1'b1;
      loaded_d = 1'b1;
      mask_d   = '0;
    end
    case (state_q)
      IDLE:    if (match && !complete) state_d = COLLECT;
      COLLECT: if (complete)           state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      shadow_q <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      loaded_q <= 1'b0;
      fwd_q    <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      loaded_q <= loaded_d;
      fwd_q    <= conf_in_bus;
    end
  end

`ifdef CGRA_CONF_PARITY_EN
  logic err_q, err_d;

  assign err_d = err_q | (word_vld & ~parity_ok);

  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign conf_err = err_q;
`else
  assign conf_err = 1'b0;
`endif

  assign conf_fwd_bus = fwd_q;
  assign conf_out     = out_q;
  assign conf_valid   = valid_q;
  assign conf_loaded  = loaded_q;

endmodule

// File: tb/tb_cgra0_conf_receiver.sv
// Randomized and directed bench for cgra0_conf_receiver against a fragment-set reference model.
module tb_cgra0_conf_receiver;

  localparam logic [15:0] PE_ID = 16'd5;
  localparam int          NW    = 2;
  localparam int          CW    = NW * 44;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [63:0]   conf_in_bus = '0;
  logic [63:0]   conf_fwd_bus;
  logic [CW-1:0] conf_out;
  logic          conf_valid, conf_loaded, conf_err;

  cgra0_conf_receiver #(.PE_ID(PE_ID), .CONF_WORDS(NW)) dut (
    .clk          (clk),
    .rst          (rst),
    .conf_in_bus  (conf_in_bus),
    .conf_fwd_bus (conf_fwd_bus),
    .conf_out     (conf_out),
    .conf_valid   (conf_valid),
    .conf_loaded  (conf_loaded),
    .conf_err     (conf_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the set of fragments received so far for the pending configuration.
  logic [43:0]   m_shad [NW];
  bit            m_have [NW];
  logic [CW-1:0] m_out;
  bit            m_valid, m_loaded, m_err;
  logic [63:0]   m_fwd;

  localparam logic [43:0] PA = 44'h012_3456_789A;
  localparam logic [43:0] PB = 44'h0FE_DCBA_9876;
  localparam logic [43:0] PC = 44'h055_AA55_AA55;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [43:0] pl, input logic [3:0] idx, input logic [15:0] id);
    logic [63:0] w;
    w = {pl, idx, id};
`ifdef CGRA_CONF_PARITY_EN
    w[63] = ^w[62:0];
`endif
    return w;
  endfunction

  function automatic bit bad_parity(input logic [63:0] w);
`ifdef CGRA_CONF_PARITY_EN
    return ^w;
`else
    return (w == 64'hFFFF_FFFF_FFFF_FFFF) && (w != w);
`endif
  endfunction

  function automatic logic [43:0] stored(input logic [63:0] w);
`ifdef CGRA_CONF_PARITY_EN
    return {1'b0, w[62:20]};
`else
    return w[63:20];
`endif
  endfunction

  task automatic model_update(input logic [63:0] w, input logic r);
    int          idx, got;
    logic [15:0] id;
    if (!r) begin
      for (int k = 0; k < NW; k++) begin m_have[k] = 0; m_shad[k] = '0; end
      m_out = '0; m_valid = 0; m_loaded = 0; m_err = 0; m_fwd = '0;
      return;
    end
    m_fwd   = w;
    m_valid = 0;
    id      = w[15:0];
    idx     = int'(w[19:16]);
    if (w != 0 && bad_parity(w)) m_err = 1;
    if (w != 0 && !bad_parity(w) && (id == PE_ID || id == 16'hFFFF) && idx < NW) begin
      m_shad[idx] = stored(w);
      m_have[idx] = 1;
      got = 0;
      for (int k = 0; k < NW; k++) got += int'(m_have[k]);
      if (got == NW) begin
        for (int k = 0; k < NW; k++) begin m_out[k*44 +: 44] = m_shad[k]; m_have[k] = 0; end
        m_valid  = 1;
        m_loaded = 1;
      end
    end
  endtask

  task automatic step(input logic [63:0] w, input logic r);
    @(negedge clk);
    conf_in_bus = w;
    rst         = r;
    @(posedge clk);
    model_update(w, r);
    #1;
    chk("fwd",    128'(conf_fwd_bus), 128'(m_fwd));
    chk("out",    128'(conf_out),     128'(m_out));
    chk("valid",  128'(conf_valid),   128'(m_valid));
    chk("loaded", 128'(conf_loaded),  128'(m_loaded));
    chk("err",    128'(conf_err),     128'(m_err));
  endtask

  initial begin
    logic [63:0] w, rnd;
    logic [15:0] id;
    int          sel;

    // Reset with idle bus: everything must read zero.
    step(64'd0, 1'b0);
    step(64'd0, 1'b0);
    chk("rst_out", 128'(conf_out), 128'd0);
    for (int i = 0; i < 3; i++) begin
      step(64'd0, 1'b1);
      chk("idle_fwd", 128'(conf_fwd_bus), 128'd0);
    end

    // Two fragments back to back.
    step(mk(PA, 4'd0, PE_ID), 1'b1);
    chk("t2_fwd0", 128'(conf_fwd_bus), 128'(mk(PA, 4'd0, PE_ID)));
    chk("t2_novalid", 128'(conf_valid), 128'd0);
    step(mk(PB, 4'd1, PE_ID), 1'b1);
    chk("t2_out", 128'(conf_out), 128'({PB, PA}));
    chk("t2_valid", 128'(conf_valid), 128'd1);
    chk("t2_loaded", 128'(conf_loaded), 128'd1);
    step(64'd0, 1'b1);
    chk("t2_pulse", 128'(conf_valid), 128'd0);

    // Foreign ID then only the second fragment: no commit.
    step(mk(PC, 4'd0, 16'd7), 1'b1);
    chk("t3_fwd", 128'(conf_fwd_bus), 128'(mk(PC, 4'd0, 16'd7)));
    step(mk(PC, 4'd1, PE_ID), 1'b1);
    chk("t3_hold", 128'(conf_out), 128'({PB, PA}));
    chk("t3_novalid", 128'(conf_valid), 128'd0);

    // Fresh start, then duplicate fragment 0: last write wins.
    step(64'd0, 1'b0);
    step(mk(PA, 4'd0, PE_ID), 1'b1);
    step(mk(PC, 4'd0, PE_ID), 1'b1);
    chk("t4_novalid", 128'(conf_valid), 128'd0);
    step(mk(PB, 4'd1, PE_ID), 1'b1);
    chk("t4_out", 128'(conf_out), 128'({PB, PC}));
    chk("t4_valid", 128'(conf_valid), 128'd1);

    // Broadcast plus an out-of-range index.
    step(mk(PC, 4'd0, 16'hFFFF), 1'b1);
    step(mk(PA, 4'd1, 16'hFFFF), 1'b1);
    chk("t5_out", 128'(conf_out), 128'({PA, PC}));
    step(mk(PB, 4'd3, 16'hFFFF), 1'b1);
    chk("t5_oor_out", 128'(conf_out), 128'({PA, PC}));
    chk("t5_oor_fwd", 128'(conf_fwd_bus), 128'(mk(PB, 4'd3, 16'hFFFF)));

    // Reset mid-collection discards the partial set.
    step(mk(PA, 4'd0, PE_ID), 1'b1);
    step(64'd0, 1'b0);
    step(64'd0, 1'b1);
    step(mk(PB, 4'd1, PE_ID), 1'b1);
    chk("t6_nocommit", 128'(conf_valid), 128'd0);
    chk("t6_zero", 128'(conf_out), 128'd0);
    step(mk(PA, 4'd0, PE_ID), 1'b1);
    step(mk(PB, 4'd1, PE_ID), 1'b1);
    chk("t6_commit", 128'(conf_out), 128'({PB, PA}));

`ifdef CGRA_CONF_PARITY_EN
    // Bad parity: flagged, forwarded, not consumed.
    w = mk(PC, 4'd0, PE_ID) ^ 64'h0000_0100_0000_0000;
    step(w, 1'b1);
    chk("par_err", 128'(conf_err), 128'd1);
    chk("par_fwd", 128'(conf_fwd_bus), 128'(w));
    step(mk(PC, 4'd1, PE_ID), 1'b1);
    chk("par_nocommit", 128'(conf_valid), 128'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 99);
      rnd = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       id = 16'd7;
        1:       id = 16'hFFFF;
        2:       id = 16'($urandom);
        default: id = PE_ID;
      endcase
      w = mk(rnd[43:0], 4'($urandom_range(0, 3)), id);
`ifdef CGRA_CONF_PARITY_EN
      if ($urandom_range(0, 9) == 0) w[63] = ~w[63];
`endif
      if (sel < 2)       step(64'd0, 1'b0);
      else if (sel < 20) step(64'd0, 1'b1);
      else               step(w, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cgra0_conf_receiver.md
Name: cgra0_conf_receiver

Overview:
- Per-PE receive end of the 64-bit configuration broadcast bus driven by the configuration controller.
- Snoops each non-zero bus word and matches its destination ID against the PE's own ID.
- Collects the PE's CONF_WORDS payload fragments in a shadow register, then commits them atomically to the active configuration.
- Re-registers every word onto a forward bus so PEs can be daisy-chained, one cycle per hop.

Parameters:
PE_ID, 0, 16-bit ID of this PE; 16'hFFFF is reserved for broadcast.
CONF_WORDS, 2, payload fragments per full PE configuration; legal range 1..16.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; one clock, synchronous, active-low (rst=0 resets)
conf_in_bus  input  64  configuration word from controller or previous hop; 0 = idle
conf_fwd_bus  output  64  conf_in_bus delayed one cycle, unmodified
conf_out  output  CONF_WORDS*44  active configuration; fragment k occupies [44k+43:44k]
conf_valid  output  1  one-cycle pulse when conf_out updates
conf_loaded  output  1  high once at least one full configuration has been committed
conf_err  output  1  sticky parity error flag (optional feature only; otherwise tied 0)

Behaviour:
- Word format: [15:0] dest_id; [19:16] frag_idx; [63:20] payload (44 bits).
- Word valid iff conf_in_bus != 0. An all-zero word is never consumed.
- Match iff word valid AND (dest_id == PE_ID OR dest_id == 16'hFFFF) AND frag_idx < CONF_WORDS.
- Reset (rst=0 at an edge) clears:
  - conf_fwd_bus, conf_out, conf_valid, conf_loaded, conf_err
  - shadow registers and fragment mask
  - state returns to IDLE
- Reset mid-collection discards the partial shadow. conf_out stays 0 until a new full set arrives.
- Forwarding:
  - conf_fwd_bus <= conf_in_bus every cycle, including unmatched and out-of-range words.
  - Latency exactly 1 cycle; no filtering.
- FSM state IDLE (mask == 0):
  - Matched word at edge: shadow[frag_idx] <= payload; mask[frag_idx] <= 1; go to COLLECT.
  - If CONF_WORDS == 1, commit on the same edge instead.
- FSM state COLLECT:
  - Each matched word writes its shadow slot and sets its mask bit.
  - Duplicate frag_idx overwrites the slot (last write wins); mask unchanged.
  - When the mask including the current word equals all-ones, commit on that edge.
- Commit (same edge as the completing word):
  - conf_out <= shadow with the current word's payload merged in.
  - conf_valid <= 1 for exactly one cycle; conf_loaded <= 1.
  - mask <= 0; state returns to IDLE.
- Latency: last fragment on conf_in_bus at cycle t → conf_out and conf_valid visible at t+1.
- conf_out never changes except at commit; partial collection never disturbs it.
- Back-to-back words every cycle must be accepted; there is no backpressure.
- Unmatched or out-of-range words never touch shadow, mask, or FSM state.
- Non-zero word with frag_idx >= CONF_WORDS: ignored locally, still forwarded.
- Reconfiguration: a new full set commits again and pulses conf_valid again; conf_loaded stays 1.

Optional Feature:
CGRA_CONF_PARITY_EN
- Defined:
  - Bit 63 is an even-parity bit over bits [63:0]. Payload is [62:20] and bit 43 of each fragment is stored as 0.
  - A valid word with odd overall parity is not consumed: no shadow/mask update.
  - Such a word sets conf_err (sticky until reset) but is still forwarded.
- Undefined:
  - Bit 63 is payload.
  - conf_err is constant 0.

Test Plan:
- Reset, PE_ID=5, CONF_WORDS=2, bus idle → all outputs 0, conf_fwd_bus 0 at every cycle.
- Words {payload A, idx0, id5} then {payload B, idx1, id5} on consecutive cycles → conf_out={B,A} and conf_valid=1 exactly at the cycle after the second word; conf_loaded=1; each word appears on conf_fwd_bus one cycle later.
- Word id=7 idx0, then id5 idx1 only → no commit, conf_out unchanged; forward bus carries both.
- idx0=A, idx0=C (duplicate), idx1=B, all for id5 → conf_out={B,C}; conf_valid pulses once.
- Broadcast id 16'hFFFF with idx 0,1, then idx 3 (out of range) → commit after idx1; idx3 is ignored locally but forwarded.
- Assert rst=0 after idx0 only, release, send idx1 → no commit. Then send idx0 and idx1 → commit.
- With CGRA_CONF_PARITY_EN: word with bad parity → conf_err=1, mask unchanged, word forwarded.
